// File: rtl/uart_rx_packetizer.sv
// uart_rx_packetizer: gathers uart_rx characters into wide host packets,
// discarding partial packets on framing error or idle timeout.
module uart_rx_packetizer #(
  parameter int data_bits_p      = 8,
  parameter int packet_bytes_p   = 16,
  parameter int timeout_cycles_p = 104160,
  localparam int packet_width_lp = data_bits_p*packet_bytes_p
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       rx_v_i,
  input  logic [data_bits_p-1:0]     rx_i,
  input  logic                       rx_error_i,
  output logic                       v_o,
  output logic [packet_width_lp-1:0] packet_o,
  input  logic                       yumi_i,
  output logic                       timeout_o,
  output logic                       frame_error_o,
  output logic [15:0]                drop_count_o
);

  localparam int cnt_w_lp =
    $clog2(packet_bytes_p+1);
  localparam int tmr_w_lp =
    (timeout_cycles_p > 1)
      ? $clog2(timeout_cycles_p) : 1;
  localparam logic [cnt_w_lp-1:0] last_lp =
    cnt_w_lp'(packet_bytes_p-1);
  localparam logic [tmr_w_lp-1:0] tmr_max_lp =
    tmr_w_lp'(timeout_cycles_p-1);

  typedef enum logic {
    FILL_S,
    HELD_S
  } state_e;

  state_e                     state_q;
  logic [cnt_w_lp-1:0]        cnt_q;
  logic [tmr_w_lp-1:0]        tmr_q;
  logic [packet_width_lp-1:0] buf_q;
  logic [packet_width_lp-1:0] pkt_q;
  logic                       v_q;
  logic                       timeout_q;
  logic                       ferr_q;
  logic [15:0]                drop_q;

  logic                xfer;
  logic                filling;
  logic [cnt_w_lp-1:0] base_cnt;
  logic                acc;
  logic                err;
  logic                tmo;
  logic                tick;
  logic                drop;

  // A completed buffer leaves HELD as soon as the output slot frees up;
  // that same cycle already behaves as FILL with an empty buffer.
  assign xfer     = (state_q == HELD_S)
                  & (~v_q | yumi_i);
  assign filling  = (state_q == FILL_S) | xfer;
  assign base_cnt = xfer ? '0 : cnt_q;

  assign acc  = filling & rx_v_i & ~rx_error_i;
  assign err  = filling & rx_error_i;
  assign tmo  = filling & ~rx_v_i & ~rx_error_i
              & (base_cnt != '0)
              & (tmr_q == tmr_max_lp);
  assign tick = filling & ~rx_v_i & ~rx_error_i
              & (base_cnt != '0)
              & (tmr_q != tmr_max_lp);
  assign drop = (state_q == HELD_S) & ~xfer
              & rx_v_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= FILL_S;
      cnt_q     <= '0;
      tmr_q     <= '0;
      buf_q     <= '0;
      pkt_q     <= '0;
      v_q       <= 1'b0;
      timeout_q <= 1'b0;
      ferr_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      timeout_q <= 1'b0;
      ferr_q    <= 1'b0;

      if (xfer) begin
        pkt_q   <= buf_q;
        v_q     <= 1'b1;
        state_q <= FILL_S;
        cnt_q   <= '0;
        tmr_q   <= '0;
      end else if (yumi_i) begin
        v_q <= 1'b0;
      end

      unique case (1'b1)
        acc: begin
          for (int k = 0; k < packet_bytes_p; k++) begin
            if (base_cnt == cnt_w_lp'(k))
              buf_q[k*data_bits_p +: data_bits_p] <= rx_i;
          end
          cnt_q <= base_cnt + 1'b1;
          tmr_q <= '0;
          if (base_cnt == last_lp)
            state_q <= HELD_S;
        end
        err: begin
          cnt_q  <= '0;
          tmr_q  <= '0;
          ferr_q <= 1'b1;
        end
        tmo: begin
          cnt_q     <= '0;
          tmr_q     <= '0;
          timeout_q <= 1'b1;
        end
        tick: begin
          tmr_q <= tmr_q + 1'b1;
        end
        default: begin
        end
      endcase

      if (drop && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end
  end

  assign v_o           = v_q;
  assign packet_o      = pkt_q;
  assign timeout_o     = timeout_q;
  assign frame_error_o = ferr_q;
  assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// tb_uart_rx_packetizer: directed stimulus with a queue scoreboard;
// the monitor pops an expected packet on every consumed output.
module tb_uart_rx_packetizer;

  localparam int W = 8;
  localparam int N = 4;
  localparam int T = 50;

  logic          clk_i      = 1'b0;
  logic          reset_i    = 1'b0;
  logic          rx_v_i     = 1'b0;
  logic [W-1:0]  rx_i       = '0;
  logic          rx_error_i = 1'b0;
  logic          yumi_i     = 1'b0;
  logic          v_o;
  logic [W*N-1:0] packet_o;
  logic          timeout_o;
  logic          frame_error_o;
  logic [15:0]   drop_count_o;

  int checks  = 0;
  int errors  = 0;
  int tmo_cnt = 0;
  int fe_cnt  = 0;
  int t0;
  int f0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] p;

  always #5 clk_i = ~clk_i;

  uart_rx_packetizer #(
    .data_bits_p      (W),
    .packet_bytes_p   (N),
    .timeout_cycles_p (T)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .rx_v_i        (rx_v_i),
    .rx_i          (rx_i),
    .rx_error_i    (rx_error_i),
    .v_o           (v_o),
    .packet_o      (packet_o),
    .yumi_i        (yumi_i),
    .timeout_o     (timeout_o),
    .frame_error_o (frame_error_o),
    .drop_count_o  (drop_count_o)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_i) begin
      tmo_cnt += int'(timeout_o);
      fe_cnt  += int'(frame_error_o);
      if (v_o && yumi_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_unexpected got %h want none",
                   packet_o);
        end else begin
          mon_exp = exp_q.pop_front();
          if (packet_o !== mon_exp) begin
            errors++;
            $display("FAIL mon_packet got %h want %h",
                     packet_o, mon_exp);
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] b);
    @(posedge clk_i); #1;
    rx_v_i = 1'b1;
    rx_i   = b;
    @(posedge clk_i); #1;
    rx_v_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++)
      @(posedge clk_i);
    repeat (2) @(posedge clk_i);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_v", v_o, 0);
    chk("rst_pkt", packet_o, 0);
    chk("rst_tmo", timeout_o, 0);
    chk("rst_ferr", frame_error_o, 0);
    chk("rst_drop", drop_count_o, 0);
    @(negedge clk_i);
    reset_i = 1'b1;

    // basic packet, consumer always ready
    yumi_i = 1'b1;
    exp_q.push_back(32'h44332211);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    @(negedge clk_i);
    chk("t1_lat0", v_o, 0);
    @(negedge clk_i);
    chk("t1_lat1", v_o, 1);
    @(negedge clk_i);
    chk("t1_pulse", v_o, 0);
    drain("t1_drain");
    chk("t1_tmo", tmo_cnt, 0);
    chk("t1_fe", fe_cnt, 0);

    // backpressure: one held, one pending, one dropped
    yumi_i = 1'b0;
    exp_q.push_back(32'h03020100);
    exp_q.push_back(32'h07060504);
    for (int i = 0; i < 8; i++) send(8'(i));
    send(8'hAA);
    repeat (3) @(posedge clk_i);
    #1;
    chk("t2_v", v_o, 1);
    chk("t2_pkt0", packet_o, 32'h03020100);
    chk("t2_drop", drop_count_o, 1);
    @(posedge clk_i); #1;
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    chk("t2_b2b_v", v_o, 1);
    chk("t2_pkt1", packet_o, 32'h07060504);
    @(posedge clk_i); #1;
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    chk("t2_empty", v_o, 0);
    drain("t2_drain");

    // framing error discards partial packet
    yumi_i = 1'b1;
    f0 = fe_cnt;
    exp_q.push_back(32'hA3A2A1A0);
    send(8'h01);
    send(8'h02);
    @(posedge clk_i); #1;
    rx_error_i = 1'b1;
    @(posedge clk_i); #1;
    rx_error_i = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
    drain("t3_drain");
    chk("t3_fe", fe_cnt - f0, 1);

    // timeout fires exactly T idle edges after a byte
    t0 = tmo_cnt;
    exp_q.push_back(32'h13121110);
    send(8'h55);
    repeat (T-1) @(posedge clk_i);
    #1;
    chk("t4_pre", timeout_o, 0);
    @(posedge clk_i); #1;
    chk("t4_pulse", timeout_o, 1);
    @(posedge clk_i); #1;
    chk("t4_post", timeout_o, 0);
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    drain("t4_drain");
    chk("t4_tmo", tmo_cnt - t0, 1);

    // byte arriving on the expiry edge wins
    t0 = tmo_cnt;
    exp_q.push_back(32'h04030201);
    send(8'h01);
    repeat (T-2) @(posedge clk_i);
    send(8'h02);
    repeat (T-2) @(posedge clk_i);
    send(8'h03);
    send(8'h04);
    drain("t4b_drain");
    chk("t4b_tmo", tmo_cnt - t0, 0);

    // asynchronous reset mid-packet
    yumi_i = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h5A);
    send(8'hE0);
    send(8'hE1);
    chk("t5_pre_v", v_o, 1);
    chk("t5_pre_drop", drop_count_o, 1);
    @(posedge clk_i); #3;
    reset_i = 1'b0;
    #1;
    chk("t5_v", v_o, 0);
    chk("t5_pkt", packet_o, 0);
    chk("t5_drop", drop_count_o, 0);
    chk("t5_tmo", timeout_o, 0);
    chk("t5_fe", frame_error_o, 0);
    @(negedge clk_i);
    reset_i = 1'b1;
    yumi_i  = 1'b1;
    exp_q.push_back(32'hC3C2C1C0);
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i));
    drain("t5_drain");

    // 40-byte stream forms 10 packets
    t0 = tmo_cnt;
    f0 = fe_cnt;
    for (int n = 0; n < 10; n++) begin
      p = {8'(4*n+3), 8'(4*n+2),
           8'(4*n+1), 8'(4*n)};
      exp_q.push_back(p);
    end
    for (int i = 0; i < 40; i++) send(8'(i));
    drain("t6_drain");
    chk("t6_drop", drop_count_o, 0);
    chk("t6_tmo", tmo_cnt - t0, 0);
    chk("t6_fe", fe_cnt - f0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
